// File: rtl/issue_dispatch_unit.sv
// Decode/issue stage: in-order instruction queue feeding reservation-station classes,
// with per-class occupancy counters fed back from the RS/CDB release pulses.
module issue_dispatch_unit #(
    parameter int IQ_DEPTH = 4,
    parameter int N_ADD_RS = 3,
    parameter int N_MUL_RS = 2,
    parameter int N_LD_RS  = 2,
    parameter int N_ST_RS  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        instr_valid,
    input  logic [31:0] instr_in,
    output logic        instr_ready,
    output logic        issue_valid,
    output logic [1:0]  issue_class,
    output logic [2:0]  issue_alu_ctrl,
    output logic [1:0]  issue_imm_src,
    output logic [31:0] issue_instr,
    output logic        unsup_pulse,
    input  logic        add_free,
    input  logic        mul_free,
    input  logic        ld_free,
    input  logic        st_free,
    output logic        occ_err
);

    localparam int AW = $clog2(IQ_DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic       sup;
        logic [1:0] cls;
        logic [2:0] alu;
        logic [1:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d     = '0;
        d.sup = 1'b1;
        case (w[6:0])
            7'b0000011: d.cls = 2'b10;
            7'b0100011: begin
                d.cls = 2'b11;
                d.imm = 2'b01;
            end
            7'b0110011: begin
                case (w[14:12])
                    3'b000: begin
                        if (w[31:25] == 7'b0100000) begin
                            d.alu = 3'b001;
                        end else if (w[31:25] == 7'b0000001) begin
                            d.cls = 2'b01;
                            d.alu = 3'b110;
                        end
                    end
                    3'b010:  d.alu = 3'b101;
                    3'b110:  d.alu = 3'b011;
                    3'b111:  d.alu = 3'b010;
                    default: d.sup = 1'b0;
                endcase
            end
            // Immediate ALU ops ignore funct7, so no SUB/MUL forms exist here
            7'b0010011: begin
                case (w[14:12])
                    3'b000:  d.alu = 3'b000;
                    3'b010:  d.alu = 3'b101;
                    3'b110:  d.alu = 3'b011;
                    3'b111:  d.alu = 3'b010;
                    default: d.sup = 1'b0;
                endcase
            end
            default: d.sup = 1'b0;
        endcase
        return d;
    endfunction

    logic [31:0]   mem_q [IQ_DEPTH];
    logic [31:0]   mem_d [IQ_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          full, empty, push, can_pop, pop_sup, pop_unsup;
    logic [31:0]   head;
    dec_t          head_dec;
    logic [3:0]    free_vec, cls_full, underflow;

    assign full        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign instr_ready = !full;
    assign push        = instr_valid && !full && !flush;
    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign head_dec    = decode(head);
    assign free_vec    = {st_free, ld_free, mul_free, add_free};

    // Unsupported words never wait on an RS slot; they are simply dropped
    assign can_pop   = !empty && !flush && (!head_dec.sup || !cls_full[head_dec.cls]);
    assign pop_sup   = can_pop && head_dec.sup;
    assign pop_unsup = can_pop && !head_dec.sup;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = instr_in;
                wr_ptr_d                = wr_ptr_q + PW'(1);
            end
            if (can_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_rs
        localparam int N = (c == 0) ? N_ADD_RS : (c == 1) ? N_MUL_RS : (c == 2) ? N_LD_RS : N_ST_RS;
        localparam int W = $clog2(N + 1);
        logic [W-1:0] cnt_q, cnt_d;
        logic         alloc;

        assign alloc        = pop_sup && (head_dec.cls == 2'(c));
        assign cls_full[c]  = (cnt_q >= W'(N));
        assign underflow[c] = !alloc && free_vec[c] && (cnt_q == '0);

        always_comb begin
            cnt_d = cnt_q;
            if (alloc && !free_vec[c]) begin
                cnt_d = cnt_q + W'(1);
            end else if (!alloc && free_vec[c] && (cnt_q != '0)) begin
                cnt_d = cnt_q - W'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    logic        issue_valid_q, issue_valid_d, unsup_pulse_q, unsup_pulse_d, occ_err_q, occ_err_d;
    logic [1:0]  issue_class_q, issue_class_d, issue_imm_src_q, issue_imm_src_d;
    logic [2:0]  issue_alu_ctrl_q, issue_alu_ctrl_d;
    logic [31:0] issue_instr_q, issue_instr_d;

    always_comb begin
        issue_valid_d    = pop_sup;
        unsup_pulse_d    = pop_unsup;
        issue_class_d    = issue_class_q;
        issue_alu_ctrl_d = issue_alu_ctrl_q;
        issue_imm_src_d  = issue_imm_src_q;
        issue_instr_d    = issue_instr_q;
        occ_err_d        = occ_err_q | (|underflow);
        if (pop_sup) begin
            issue_class_d    = head_dec.cls;
            issue_alu_ctrl_d = head_dec.alu;
            issue_imm_src_d  = head_dec.imm;
            issue_instr_d    = head;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_valid_q    <= 1'b0;
            unsup_pulse_q    <= 1'b0;
            occ_err_q        <= 1'b0;
            issue_class_q    <= '0;
            issue_alu_ctrl_q <= '0;
            issue_imm_src_q  <= '0;
            issue_instr_q    <= '0;
        end else begin
            issue_valid_q    <= issue_valid_d;
            unsup_pulse_q    <= unsup_pulse_d;
            occ_err_q        <= occ_err_d;
            issue_class_q    <= issue_class_d;
            issue_alu_ctrl_q <= issue_alu_ctrl_d;
            issue_imm_src_q  <= issue_imm_src_d;
            issue_instr_q    <= issue_instr_d;
        end
    end

    assign issue_valid    = issue_valid_q;
    assign unsup_pulse    = unsup_pulse_q;
    assign occ_err        = occ_err_q;
    assign issue_class    = issue_class_q;
    assign issue_alu_ctrl = issue_alu_ctrl_q;
    assign issue_imm_src  = issue_imm_src_q;
    assign issue_instr    = issue_instr_q;

endmodule

// File: tb/tb_issue_dispatch_unit.sv
// Bench for issue_dispatch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_issue_dispatch_unit;

    localparam int IQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, flush, instr_valid;
    logic [31:0] instr_in;
    logic        instr_ready, issue_valid, unsup_pulse, occ_err;
    logic [1:0]  issue_class, issue_imm_src;
    logic [2:0]  issue_alu_ctrl;
    logic [31:0] issue_instr;
    logic        add_free, mul_free, ld_free, st_free;

    issue_dispatch_unit #(.IQ_DEPTH(IQ_DEPTH), .N_ADD_RS(3), .N_MUL_RS(2), .N_LD_RS(2), .N_ST_RS(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .instr_valid(instr_valid), .instr_in(instr_in),
        .instr_ready(instr_ready), .issue_valid(issue_valid), .issue_class(issue_class),
        .issue_alu_ctrl(issue_alu_ctrl), .issue_imm_src(issue_imm_src), .issue_instr(issue_instr),
        .unsup_pulse(unsup_pulse), .add_free(add_free), .mul_free(mul_free), .ld_free(ld_free),
        .st_free(st_free), .occ_err(occ_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [31:0] mq[$];
    int          mcnt[4];
    bit          mocc, exp_iv, exp_up;
    logic [1:0]  exp_cls, exp_imm;
    logic [2:0]  exp_alu;
    logic [31:0] exp_instr;

    localparam logic [31:0] ADD  = 32'h00208033, MUL = 32'h02208033, SUB = 32'h40208033;
    localparam logic [31:0] BEQ  = 32'h00208463, LW  = 32'h00012083, SW  = 32'h00112223;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_rs(input int c);
        return (c == 0) ? 3 : 2;
    endfunction

    function automatic void m_decode(input logic [31:0] w, output bit sup, output int cls,
                                     output int alu, output int imm);
        logic [6:0] op;
        int t;
        op  = w[6:0];
        sup = 0; cls = 0; alu = 0; imm = 0;
        if (op == 7'h03) begin
            sup = 1; cls = 2;
        end else if (op == 7'h23) begin
            sup = 1; cls = 3; imm = 1;
        end else if (op == 7'h33 || op == 7'h13) begin
            case (w[14:12])
                3'd0: t = 0;
                3'd2: t = 5;
                3'd6: t = 3;
                3'd7: t = 2;
                default: t = -1;
            endcase
            if (t >= 0) begin
                sup = 1; alu = t;
                if (op == 7'h33 && w[14:12] == 3'd0) begin
                    if (w[31:25] == 7'h20) alu = 1;
                    else if (w[31:25] == 7'h01) begin cls = 1; alu = 6; end
                end
            end
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int c = 0; c < 4; c++) mcnt[c] = 0;
        mocc = 0; exp_iv = 0; exp_up = 0;
        exp_cls = '0; exp_alu = '0; exp_imm = '0; exp_instr = '0;
    endfunction

    function automatic void model_step(input bit v, input logic [31:0] w, input bit fl, input logic [3:0] fr);
        bit full, pop, sup;
        int cls, alu, imm, alloc_c;
        full = (mq.size() == IQ_DEPTH);
        pop = 0; alloc_c = -1;
        exp_iv = 0; exp_up = 0;
        if (!fl && mq.size() > 0) begin
            m_decode(mq[0], sup, cls, alu, imm);
            if (!sup) begin
                pop = 1; exp_up = 1;
            end else if (mcnt[cls] < n_rs(cls)) begin
                pop = 1; exp_iv = 1; alloc_c = cls;
                exp_cls = 2'(cls); exp_alu = 3'(alu); exp_imm = 2'(imm); exp_instr = mq[0];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (alloc_c == c && !fr[c]) mcnt[c]++;
            else if (alloc_c != c && fr[c]) begin
                if (mcnt[c] == 0) mocc = 1;
                else mcnt[c]--;
            end
        end
        if (fl) mq.delete();
        else begin
            if (pop) mq.delete(0);
            if (v && !full) mq.push_back(w);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_ready", 32'(instr_ready), 32'(mq.size() != IQ_DEPTH));
            chk("issue_valid", 32'(issue_valid), 32'(exp_iv));
            chk("unsup_pulse", 32'(unsup_pulse), 32'(exp_up));
            chk("occ_err", 32'(occ_err), 32'(mocc));
            chk("not_both", 32'(issue_valid & unsup_pulse), 32'h0);
            if (exp_iv) begin
                chk("issue_class", 32'(issue_class), 32'(exp_cls));
                chk("issue_alu", 32'(issue_alu_ctrl), 32'(exp_alu));
                chk("issue_imm", 32'(issue_imm_src), 32'(exp_imm));
                chk("issue_instr", issue_instr, exp_instr);
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge
    task automatic step(input bit v, input logic [31:0] w, input bit fl, input logic [3:0] fr);
        instr_valid = v; instr_in = w; flush = fl;
        {st_free, ld_free, mul_free, add_free} = fr;
        @(posedge clk);
        model_step(v, w, fl, fr);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 4'b0000);
    endtask

    task automatic do_reset(input string tag);
        #2;
        instr_valid = 0; instr_in = '0; flush = 0;
        {st_free, ld_free, mul_free, add_free} = 4'b0000;
        reset = 1'b1;
        model_reset();
        #1;
        chk({tag, "_rst_ready"}, 32'(instr_ready), 32'h1);
        chk({tag, "_rst_valid"}, 32'(issue_valid), 32'h0);
        chk({tag, "_rst_unsup"}, 32'(unsup_pulse), 32'h0);
        chk({tag, "_rst_occ"}, 32'(occ_err), 32'h0);
        chk({tag, "_rst_instr"}, issue_instr, 32'h0);
        chk({tag, "_rst_fields"}, 32'({issue_class, issue_alu_ctrl, issue_imm_src}), 32'h0);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] pool[14] = '{ADD, MUL, SUB, BEQ, LW, SW, 32'h00500093, 32'h0050a093, 32'h0050e093,
                             32'h0050f093, 32'h0020a033, 32'h0020c033, 32'h0000006f, 32'h00109093};

    initial begin
        reset = 1'b1; flush = 0; instr_valid = 0; instr_in = '0;
        {st_free, ld_free, mul_free, add_free} = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset("init");
        chk_en = 1'b1;

        // Basic flow: add then mul
        step(1, ADD, 0, 4'b0000);
        chk("flow_lat1", 32'(issue_valid), 32'h0);
        step(1, MUL, 0, 4'b0000);
        chk("flow_v1", 32'(issue_valid), 32'h1);
        chk("flow_cls1", 32'({issue_class, issue_alu_ctrl}), 32'h00);
        idle();
        chk("flow_v2", 32'(issue_valid), 32'h1);
        chk("flow_cls2", 32'({issue_class, issue_alu_ctrl}), 32'b01_110);
        idle();

        // MUL RS full stall
        do_reset("stall");
        step(1, MUL | 32'h80, 0, 4'b0000);
        step(1, MUL | 32'h100, 0, 4'b0000);
        step(1, MUL | 32'h180, 0, 4'b0000);
        idle();
        chk("stall_held", 32'(issue_valid), 32'h0);
        step(0, 32'h0, 0, 4'b0010);
        chk("stall_free_edge", 32'(issue_valid), 32'h0);
        idle();
        chk("stall_release", 32'(issue_valid), 32'h1);
        chk("stall_instr", issue_instr, MUL | 32'h180);

        // IQ full behind a blocked head (MUL count is 2 again)
        for (int i = 1; i <= 4; i++) step(1, MUL | (32'(i) << 7), 0, 4'b0000);
        chk("iqfull_ready", 32'(instr_ready), 32'h0);
        step(1, MUL | (32'd5 << 7), 0, 4'b0000);
        chk("iqfull_reject", 32'(instr_ready), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 32'h0, 0, 4'b0010);
            idle();
            chk("iqfull_order", issue_instr, MUL | (32'(i) << 7));
        end
        idle();
        chk("iqfull_drained", 32'(mq.size()), 32'h0);

        // Unsupported drop
        do_reset("unsup");
        step(1, BEQ, 0, 4'b0000);
        step(1, SUB, 0, 4'b0000);
        chk("unsup_pulse1", 32'({unsup_pulse, issue_valid}), 32'b10);
        idle();
        chk("unsup_sub", 32'({issue_valid, issue_class, issue_alu_ctrl, issue_imm_src}), 32'b1_00_001_00);
        idle();

        // Simultaneous alloc/free and underflow
        do_reset("occ");
        step(1, ADD, 0, 4'b0000);
        step(1, ADD, 0, 4'b0000);
        step(0, 32'h0, 0, 4'b0001);
        chk("occ_allocfree_iv", 32'(issue_valid), 32'h1);
        chk("occ_no_err", 32'(occ_err), 32'h0);
        step(1, ADD, 0, 4'b0000);
        step(1, ADD, 0, 4'b0000);
        step(1, ADD, 0, 4'b0000);
        idle();
        chk("occ_add_full", 32'(issue_valid), 32'h0);
        step(0, 32'h0, 0, 4'b0100);
        chk("occ_err_set", 32'(occ_err), 32'h1);
        idle();
        chk("occ_err_sticky", 32'(occ_err), 32'h1);

        // Flush with queued words, then async reset right after an issue
        do_reset("flush");
        for (int i = 0; i < 5; i++) step(1, MUL | (32'(i) << 7), 0, 4'b0000);
        chk("flush_pre_q", 32'(mq.size()), 32'h3);
        step(1, ADD, 1, 4'b1000);
        chk("flush_ready", 32'(instr_ready), 32'h1);
        chk("flush_noissue", 32'({issue_valid, unsup_pulse}), 32'h0);
        chk("flush_occ", 32'(occ_err), 32'h1);
        idle();
        chk("flush_empty", 32'(issue_valid), 32'h0);
        step(1, MUL | 32'h700, 0, 4'b0000);
        step(0, 32'h0, 0, 4'b0010);
        chk("flush_cnt_kept", 32'(issue_valid), 32'h0);
        idle();
        chk("flush_issue", 32'(issue_valid), 32'h1);
        do_reset("midrun");

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] w;
            logic [3:0]  fr;
            w = ($urandom_range(0, 9) == 0) ? $urandom() : pool[$urandom_range(0, 13)];
            for (int c = 0; c < 4; c++) fr[c] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 9) < 7, w, $urandom_range(0, 49) == 0, fr);
            if ($urandom_range(0, 999) == 0) do_reset("rand");
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
